// File: rtl/new_means_calc.sv
// new_means_calc: end-of-pass k-means centroid update. Divides each centroid's
// coordinate sums by its point count (7 parallel restoring dividers, one bit per
// cycle) and emits one saturated centroid word per centroid, tagged by index.
// Centroids with zero points re-emit their current value.
// Optional build macro: MEANS_ROUND_EN (round-half-up instead of truncation).
module new_means_calc #(
    localparam int unsigned coord_num         = 7,
    localparam int unsigned coord_width       = 13,
    localparam int unsigned accum_coord_width = 22,
    localparam int unsigned count_width       = 10,
    localparam int unsigned data_width        = coord_num * coord_width,
    localparam int unsigned accum_width       = coord_num * accum_coord_width
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [accum_width-1:0] accum_1,
    input  logic [accum_width-1:0] accum_2,
    input  logic [accum_width-1:0] accum_3,
    input  logic [accum_width-1:0] accum_4,
    input  logic [accum_width-1:0] accum_5,
    input  logic [accum_width-1:0] accum_6,
    input  logic [accum_width-1:0] accum_7,
    input  logic [accum_width-1:0] accum_8,
    input  logic [count_width-1:0] cnt_1,
    input  logic [count_width-1:0] cnt_2,
    input  logic [count_width-1:0] cnt_3,
    input  logic [count_width-1:0] cnt_4,
    input  logic [count_width-1:0] cnt_5,
    input  logic [count_width-1:0] cnt_6,
    input  logic [count_width-1:0] cnt_7,
    input  logic [count_width-1:0] cnt_8,
    input  logic [data_width-1:0]  centroid_reg_1,
    input  logic [data_width-1:0]  centroid_reg_2,
    input  logic [data_width-1:0]  centroid_reg_3,
    input  logic [data_width-1:0]  centroid_reg_4,
    input  logic [data_width-1:0]  centroid_reg_5,
    input  logic [data_width-1:0]  centroid_reg_6,
    input  logic [data_width-1:0]  centroid_reg_7,
    input  logic [data_width-1:0]  centroid_reg_8,
    output logic [data_width-1:0]  new_centroid,
    output logic [2:0]             cent_cnt,
    output logic                   new_centroid_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned dvd_width = accum_coord_width + 1;
    localparam int unsigned rem_width = count_width;
    localparam logic [4:0]  last_step = 5'(dvd_width - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t                   state;
    logic [2:0]               k;
    logic [4:0]               step;
    logic [count_width-1:0]   divisor;
    logic [dvd_width-1:0]     dvd      [coord_num];
    logic [rem_width-1:0]     rem      [coord_num];

    logic [accum_width-1:0]   acc_sel;
    logic [count_width-1:0]   cnt_sel;
    logic [data_width-1:0]    reg_sel;
    logic [dvd_width-1:0]     dvd_init [coord_num];
    logic [rem_width:0]       rem_sh   [coord_num];
    logic [rem_width-1:0]     rem_nxt  [coord_num];
    logic [dvd_width-1:0]     dvd_nxt  [coord_num];
    logic [data_width-1:0]    quo_word;

    // Select the inputs of the centroid currently being processed
    always_comb begin
        acc_sel = '0;
        cnt_sel = '0;
        reg_sel = '0;
        case (k)
            3'd0: begin acc_sel = accum_1; cnt_sel = cnt_1; reg_sel = centroid_reg_1; end
            3'd1: begin acc_sel = accum_2; cnt_sel = cnt_2; reg_sel = centroid_reg_2; end
            3'd2: begin acc_sel = accum_3; cnt_sel = cnt_3; reg_sel = centroid_reg_3; end
            3'd3: begin acc_sel = accum_4; cnt_sel = cnt_4; reg_sel = centroid_reg_4; end
            3'd4: begin acc_sel = accum_5; cnt_sel = cnt_5; reg_sel = centroid_reg_5; end
            3'd5: begin acc_sel = accum_6; cnt_sel = cnt_6; reg_sel = centroid_reg_6; end
            3'd6: begin acc_sel = accum_7; cnt_sel = cnt_7; reg_sel = centroid_reg_7; end
            3'd7: begin acc_sel = accum_8; cnt_sel = cnt_8; reg_sel = centroid_reg_8; end
        endcase
    end

    // Dividend per coordinate; the rounding bias keeps it within 23 bits
    always_comb begin
        for (int j = 0; j < int'(coord_num); j++) begin
`ifdef MEANS_ROUND_EN
            dvd_init[j] = dvd_width'(acc_sel[accum_coord_width*j +: accum_coord_width])
                        + dvd_width'(cnt_sel >> 1);
`else
            dvd_init[j] = dvd_width'(acc_sel[accum_coord_width*j +: accum_coord_width]);
`endif
        end
    end

    // One restoring-division step per coordinate; quotient bits shift into dvd
    always_comb begin
        quo_word = '0;
        for (int j = 0; j < int'(coord_num); j++) begin
            rem_sh[j] = {rem[j], dvd[j][dvd_width-1]};
            if (rem_sh[j] >= {1'b0, divisor}) begin
                rem_nxt[j] = rem_width'(rem_sh[j] - {1'b0, divisor});
                dvd_nxt[j] = {dvd[j][dvd_width-2:0], 1'b1};
            end else begin
                rem_nxt[j] = rem_sh[j][rem_width-1:0];
                dvd_nxt[j] = {dvd[j][dvd_width-2:0], 1'b0};
            end
            quo_word[coord_width*j +: coord_width] =
                (|dvd_nxt[j][dvd_width-1:coord_width]) ? {coord_width{1'b1}}
                                                       : dvd_nxt[j][coord_width-1:0];
        end
    end

    // Control FSM, divider datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            k                  <= '0;
            step               <= '0;
            divisor            <= '0;
            new_centroid       <= '0;
            cent_cnt           <= '0;
            new_centroid_valid <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            for (int j = 0; j < int'(coord_num); j++) begin
                dvd[j] <= '0;
                rem[j] <= '0;
            end
        end else begin
            new_centroid_valid <= 1'b0;
            done               <= (state == DONE);
            case (state)
                IDLE: begin
                    // busy still high here means the done cycle: refuse a restart
                    busy <= start && !busy;
                    if (start && !busy) begin
                        k     <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    busy <= 1'b1;
                    if (cnt_sel != '0) begin
                        divisor <= cnt_sel;
                        step    <= '0;
                        for (int j = 0; j < int'(coord_num); j++) begin
                            dvd[j] <= dvd_init[j];
                            rem[j] <= '0;
                        end
                        state <= DIV;
                    end else begin
                        new_centroid       <= reg_sel;
                        cent_cnt           <= k;
                        new_centroid_valid <= 1'b1;
                        if (k == 3'd7) state <= DONE;
                        else           k     <= k + 3'd1;
                    end
                end
                DIV: begin
                    busy <= 1'b1;
                    step <= step + 5'd1;
                    for (int j = 0; j < int'(coord_num); j++) begin
                        dvd[j] <= dvd_nxt[j];
                        rem[j] <= rem_nxt[j];
                    end
                    if (step == last_step) begin
                        new_centroid       <= quo_word;
                        cent_cnt           <= k;
                        new_centroid_valid <= 1'b1;
                        if (k == 3'd7) begin
                            state <= DONE;
                        end else begin
                            k     <= k + 3'd1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_new_means_calc.sv
// tb_new_means_calc: table-driven uniform passes, hand-written corner sequences
// and random passes, all checked against a plain-arithmetic reference model.
module tb_new_means_calc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [153:0] accum_bus [8];
    logic [9:0]   cnt_v     [8];
    logic [90:0]  reg_bus   [8];
    logic [90:0]  new_centroid;
    logic [2:0]   cent_cnt;
    logic         new_centroid_valid, busy, done;

    int unsigned acc_c [8][7];
    int unsigned reg_c [8][7];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Pack per-coordinate stimulus into the port buses
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            accum_bus[k] = '0;
            reg_bus[k]   = '0;
            for (int j = 0; j < 7; j++) begin
                accum_bus[k][22*j +: 22] = 22'(acc_c[k][j]);
                reg_bus[k][13*j +: 13]   = 13'(reg_c[k][j]);
            end
        end
    end

    new_means_calc dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .accum_1(accum_bus[0]), .accum_2(accum_bus[1]), .accum_3(accum_bus[2]), .accum_4(accum_bus[3]),
        .accum_5(accum_bus[4]), .accum_6(accum_bus[5]), .accum_7(accum_bus[6]), .accum_8(accum_bus[7]),
        .cnt_1(cnt_v[0]), .cnt_2(cnt_v[1]), .cnt_3(cnt_v[2]), .cnt_4(cnt_v[3]),
        .cnt_5(cnt_v[4]), .cnt_6(cnt_v[5]), .cnt_7(cnt_v[6]), .cnt_8(cnt_v[7]),
        .centroid_reg_1(reg_bus[0]), .centroid_reg_2(reg_bus[1]), .centroid_reg_3(reg_bus[2]),
        .centroid_reg_4(reg_bus[3]), .centroid_reg_5(reg_bus[4]), .centroid_reg_6(reg_bus[5]),
        .centroid_reg_7(reg_bus[6]), .centroid_reg_8(reg_bus[7]),
        .new_centroid(new_centroid), .cent_cnt(cent_cnt),
        .new_centroid_valid(new_centroid_valid), .busy(busy), .done(done)
    );

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [90:0] act, input logic [90:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: mean of the sums, rounded or truncated, clipped to 13 bits
    function automatic int unsigned model_coord(input int k, input int j);
        longint unsigned q;
        if (cnt_v[k] == 10'd0) return reg_c[k][j];
        q = longint'(acc_c[k][j]);
`ifdef MEANS_ROUND_EN
        q = q + longint'(cnt_v[k]) / 2;
`endif
        q = q / longint'(cnt_v[k]);
        return (q > 8191) ? 32'd8191 : 32'(q);
    endfunction

    function automatic logic [90:0] model_word(input int k);
        logic [90:0] w;
        w = '0;
        for (int j = 0; j < 7; j++) w[13*j +: 13] = 13'(model_coord(k, j));
        return w;
    endfunction

    task automatic fill_uniform(input int unsigned acc, input int unsigned cnt, input int unsigned rv);
        for (int k = 0; k < 8; k++) begin
            cnt_v[k] = 10'(cnt);
            for (int j = 0; j < 7; j++) begin
                acc_c[k][j] = acc;
                reg_c[k][j] = rv;
            end
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0)      cnt_v[k] = 10'd0;
            else if ($urandom_range(0, 1) == 1) cnt_v[k] = 10'($urandom_range(1, 1023));
            else                                cnt_v[k] = 10'($urandom_range(1, 8));
            for (int j = 0; j < 7; j++) begin
                acc_c[k][j] = $urandom_range(0, 4194303);
                reg_c[k][j] = $urandom_range(0, 8191);
            end
        end
    endtask

    // Run one pass; expected edge of each valid follows from the counts alone
    task automatic run_pass(input string tag, input bit poke_start, output int done_at);
        int vt [8];
        int t, nv, done_e;
        t = 0;
        for (int k = 0; k < 8; k++) begin
            t += (cnt_v[k] != 10'd0) ? 24 : 1;
            vt[k] = t;
        end
        done_e  = t + 1;
        nv      = 0;
        done_at = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk);                 // E0
        @(negedge clk); start = 1'b0;
        for (int i = 1; i <= done_e + 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (i == 1) check_int({tag, " busy_rise"}, int'(busy), 1);
            if (new_centroid_valid) begin
                if (nv < 8) begin
                    check_int($sformatf("%s valid%0d_edge", tag, nv), i, vt[nv]);
                    check_int($sformatf("%s valid%0d_idx", tag, nv), int'(cent_cnt), nv);
                    check_word($sformatf("%s valid%0d_data", tag, nv), new_centroid, model_word(nv));
                end else begin
                    check_int({tag, " extra_valid"}, nv, 7);
                end
                nv++;
            end
            if (done) begin
                done_at = i;
                check_int({tag, " done_edge"}, i, done_e);
            end
            if (i == done_e) begin
                check_int({tag, " busy_in_done"}, int'(busy), 1);
                if (poke_start) start = 1'b1;
            end
            if (i == done_e + 1) begin
                check_int({tag, " busy_fall"}, int'(busy), 0);
                check_int({tag, " done_width"}, int'(done), 0);
            end
            if (poke_start && i == 30) start = 1'b1;
        end
        start = 1'b0;
        check_int({tag, " valid_count"}, nv, 8);
        check_int({tag, " done_seen"}, done_at, done_e);
        repeat (3) @(negedge clk);
        check_int({tag, " no_restart"}, int'(busy), 0);
        check_int({tag, " hold_idx"}, int'(cent_cnt), 7);
        check_word({tag, " hold_data"}, new_centroid, model_word(7));
    endtask

    typedef struct {
        string       name;
        int unsigned acc;
        int unsigned cnt;
        int unsigned rv;
        int unsigned exp;
        int          done_e;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int d;
`ifdef MEANS_ROUND_EN
        tbl[0] = '{"trunc_1005_10",  1005,    10,   0,    101,  193};
`else
        tbl[0] = '{"trunc_1005_10",  1005,    10,   0,    100,  193};
`endif
        tbl[1] = '{"sat_cnt1",       4194303, 1,    0,    8191, 193};
        tbl[2] = '{"max_divisor",    4194303, 1023, 0,    4100, 193};
        tbl[3] = '{"sat_cnt511",     4194303, 511,  0,    8191, 193};
        tbl[4] = '{"zero_accum",     0,       5,    0,    0,    193};
        tbl[5] = '{"all_cnt_zero",   123,     0,    4321, 4321, 9};

        fill_uniform(0, 0, 0);
        repeat (3) @(negedge clk);
        check_word("reset_data", new_centroid, '0);
        check_int("reset_idx", int'(cent_cnt), 0);
        check_int("reset_valid", int'(new_centroid_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fill_uniform(tbl[v].acc, tbl[v].cnt, tbl[v].rv);
            run_pass(tbl[v].name, 1'b0, d);
            check_int({tbl[v].name, " tbl_done"}, d, tbl[v].done_e);
            check_int({tbl[v].name, " tbl_coord0"}, int'(new_centroid[12:0]), int'(tbl[v].exp));
            check_int({tbl[v].name, " tbl_coord6"}, int'(new_centroid[90:78]), int'(tbl[v].exp));
        end

        // One empty centroid in the middle: finishes 23 cycles early
        fill_uniform(7, 1, 55);
        cnt_v[2] = 10'd0;
        for (int j = 0; j < 7; j++) reg_c[2][j] = 4321;
        run_pass("one_zero", 1'b0, d);
        check_int("one_zero done_early", d, 193 - 23);

        // Restart attempts mid-DIV and in the done cycle are ignored
        fill_random();
        run_pass("ignore_start", 1'b1, d);

        // Reset while centroid 4 divides, then a clean pass
        fill_uniform(1005, 10, 0);
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        check_int("prereset_idx", int'(cent_cnt), 2);
        check_int("prereset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_word("midrst_data", new_centroid, '0);
        check_int("midrst_idx", int'(cent_cnt), 0);
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_valid", int'(new_centroid_valid), 0);
        check_int("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        check_int("midrst_no_done", int'(done), 0);
        rst_n = 1'b1;
        fill_random();
        run_pass("after_reset", 1'b0, d);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_pass($sformatf("rand%0d", r), (r == 2), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
